// File: rtl/assoc_cache_if.sv
// Request/response/evict bundle between a requester and assoc_cache_lru.
// The master modport is the requester side. The slave modport is the cache side.
interface assoc_cache_if #(
    parameter int TAG_WIDTH  = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ENTRIES    = 8
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_op;
    logic [TAG_WIDTH-1:0]  req_tag;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  resp_valid;
    logic                  resp_ready;
    logic                  resp_hit;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  evict_valid;
    logic [TAG_WIDTH-1:0]  evict_tag;
    logic [DATA_WIDTH-1:0] evict_data;
    logic [IDX_W:0]        occupancy;

    modport master (
        output req_valid, req_op, req_tag, req_data, resp_ready,
        input  req_ready, resp_valid, resp_hit, resp_data,
               evict_valid, evict_tag, evict_data, occupancy
    );

    modport slave (
        input  req_valid, req_op, req_tag, req_data, resp_ready,
        output req_ready, resp_valid, resp_hit, resp_data,
               evict_valid, evict_tag, evict_data, occupancy
    );
endinterface

// File: rtl/assoc_cache_lru.sv
// Fully-associative tag/data cache with true-LRU replacement.
// One operation is outstanding at a time: IDLE -> EXEC|FLUSH -> RESP -> IDLE.
// The op result is registered on leaving EXEC (or on the last FLUSH step).
// resp_valid is raised one cycle later, so a response arrives 2 edges after accept.
module assoc_cache_lru #(
    parameter int TAG_WIDTH  = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ENTRIES    = 8
) (
    input logic           clk,
    input logic           rst,
    assoc_cache_if.slave  bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [1:0] OP_FLUSH = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_INVAL = 2'b11;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_FLUSH, S_RESP} state_t;
    state_t state_r, state_nx_s;

    logic [1:0]            op_r;
    logic [TAG_WIDTH-1:0]  tag_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic [IDX_W-1:0]      flush_idx_r;
    logic [ENTRIES-1:0]    valid_r, valid_nx_s;
    logic [IDX_W-1:0]      age_r    [ENTRIES];
    logic [IDX_W-1:0]      age_nx_s [ENTRIES];
    logic [TAG_WIDTH-1:0]  tag_mem_r  [ENTRIES];
    logic [DATA_WIDTH-1:0] data_mem_r [ENTRIES];

    logic                  resp_valid_r, resp_hit_r, evict_valid_r;
    logic [DATA_WIDTH-1:0] resp_data_r, evict_data_r;
    logic [TAG_WIDTH-1:0]  evict_tag_r;
    logic [IDX_W:0]        occ_r;

    logic                  accept_s, resp_done_s;
    logic                  hit_s, free_s, touch_s, wr_s, res_hit_s, res_evict_s;
    logic [IDX_W-1:0]      hit_idx_s, free_idx_s, victim_idx_s, touch_idx_s, wr_idx_s;
    logic [DATA_WIDTH-1:0] res_data_s;

    // Population count of a valid vector; result fits 0..ENTRIES.
    function automatic logic [IDX_W:0] count_valid(input logic [ENTRIES-1:0] v);
        logic [IDX_W:0] n;
        n = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            n = n + {{IDX_W{1'b0}}, v[i]};
        end
        return n;
    endfunction

    assign accept_s    = bus.req_valid && (state_r == S_IDLE);
    assign resp_done_s = (state_r == S_RESP) && resp_valid_r && bus.resp_ready;

    assign bus.req_ready   = (state_r == S_IDLE);
    assign bus.resp_valid  = resp_valid_r;
    assign bus.resp_hit    = resp_hit_r;
    assign bus.resp_data   = resp_data_r;
    assign bus.evict_valid = evict_valid_r;
    assign bus.evict_tag   = evict_tag_r;
    assign bus.evict_data  = evict_data_r;
    assign bus.occupancy   = occ_r;

    // Next-state logic for the op sequencer.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_nx_s = (bus.req_op == OP_FLUSH) ? S_FLUSH : S_EXEC;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_EXEC:  state_nx_s = S_RESP;
            S_FLUSH: begin
                if (flush_idx_r == LAST_IDX) begin
                    state_nx_s = S_RESP;
                end else begin
                    state_nx_s = S_FLUSH;
                end
            end
            S_RESP: begin
                if (resp_done_s) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_RESP;
                end
            end
            default: state_nx_s = S_IDLE;
        endcase
    end

    // Parallel tag match, lowest free line and LRU victim search.
    always_comb begin
        hit_s        = 1'b0;
        hit_idx_s    = '0;
        free_s       = 1'b0;
        free_idx_s   = '0;
        victim_idx_s = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_r[i] && (tag_mem_r[i] == tag_r)) begin
                hit_s     = 1'b1;
                hit_idx_s = IDX_W'(i);
            end
            if (age_r[i] == LAST_IDX) begin
                victim_idx_s = IDX_W'(i);
            end
        end
        // Scan downwards so the lowest invalid index wins.
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_r[i]) begin
                free_s     = 1'b1;
                free_idx_s = IDX_W'(i);
            end
        end
    end

    // Op decode: array writes, valid updates, LRU touch and response values.
    always_comb begin
        valid_nx_s  = valid_r;
        touch_s     = 1'b0;
        touch_idx_s = '0;
        wr_s        = 1'b0;
        wr_idx_s    = '0;
        res_hit_s   = 1'b0;
        res_data_s  = '0;
        res_evict_s = 1'b0;
        if (state_r == S_EXEC) begin
            case (op_r)
                OP_READ: begin
                    res_hit_s   = hit_s;
                    touch_s     = hit_s;
                    touch_idx_s = hit_idx_s;
                    res_data_s  = hit_s ? data_mem_r[hit_idx_s] : '0;
                end
                OP_WRITE: begin
                    res_hit_s  = hit_s;
                    res_data_s = data_r;
                    wr_s       = 1'b1;
                    touch_s    = 1'b1;
                    if (hit_s) begin
                        wr_idx_s = hit_idx_s;
                    end else if (free_s) begin
                        wr_idx_s             = free_idx_s;
                        valid_nx_s[free_idx_s] = 1'b1;
                    end else begin
                        wr_idx_s    = victim_idx_s;
                        res_evict_s = 1'b1;
                    end
                    touch_idx_s = wr_idx_s;
                end
                OP_INVAL: begin
                    res_hit_s = hit_s;
                    if (hit_s) begin
                        valid_nx_s[hit_idx_s] = 1'b0;
                        res_data_s            = data_mem_r[hit_idx_s];
                    end else begin
                        res_data_s = '0;
                    end
                end
                default: res_hit_s = 1'b0;
            endcase
        end else if (state_r == S_FLUSH) begin
            valid_nx_s[flush_idx_r] = 1'b0;
        end else begin
            valid_nx_s = valid_r;
        end
    end

    // LRU ages after a touch: younger lines age by one, touched line becomes MRU.
    always_comb begin
        for (int j = 0; j < ENTRIES; j++) begin
            age_nx_s[j] = age_r[j];
        end
        if (touch_s) begin
            for (int j = 0; j < ENTRIES; j++) begin
                if (age_r[j] < age_r[touch_idx_s]) begin
                    age_nx_s[j] = age_r[j] + IDX_W'(1);
                end else begin
                    age_nx_s[j] = age_r[j];
                end
            end
            age_nx_s[touch_idx_s] = '0;
        end else begin
            age_nx_s[0] = age_r[0];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Request capture, valid/age/occupancy bookkeeping and registered response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r          <= 2'b00;
            tag_r         <= '0;
            data_r        <= '0;
            flush_idx_r   <= '0;
            valid_r       <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                age_r[i] <= IDX_W'(i);
            end
            occ_r         <= '0;
            resp_valid_r  <= 1'b0;
            resp_hit_r    <= 1'b0;
            resp_data_r   <= '0;
            evict_valid_r <= 1'b0;
            evict_tag_r   <= '0;
            evict_data_r  <= '0;
        end else begin
            valid_r <= valid_nx_s;
            for (int i = 0; i < ENTRIES; i++) begin
                age_r[i] <= age_nx_s[i];
            end
            occ_r <= count_valid(valid_nx_s);
            if (accept_s) begin
                op_r        <= bus.req_op;
                tag_r       <= bus.req_tag;
                data_r      <= bus.req_data;
                flush_idx_r <= '0;
            end else if (state_r == S_FLUSH) begin
                flush_idx_r <= flush_idx_r + IDX_W'(1);
            end else begin
                flush_idx_r <= flush_idx_r;
            end
            if (state_r == S_EXEC) begin
                resp_hit_r    <= res_hit_s;
                resp_data_r   <= res_data_s;
                evict_valid_r <= res_evict_s;
                if (res_evict_s) begin
                    evict_tag_r  <= tag_mem_r[victim_idx_s];
                    evict_data_r <= data_mem_r[victim_idx_s];
                end
            end else if ((state_r == S_FLUSH) && (state_nx_s == S_RESP)) begin
                resp_hit_r    <= 1'b0;
                resp_data_r   <= '0;
                evict_valid_r <= 1'b0;
            end else if (resp_done_s) begin
                evict_valid_r <= 1'b0;
            end
            if ((state_r == S_RESP) && !resp_valid_r) begin
                resp_valid_r <= 1'b1;
            end else if (resp_done_s) begin
                resp_valid_r <= 1'b0;
            end else begin
                resp_valid_r <= resp_valid_r;
            end
        end
    end

    // Tag/data storage; contents are qualified by valid_r so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            tag_mem_r[wr_idx_s]  <= tag_r;
            data_mem_r[wr_idx_s] <= data_r;
        end
    end
endmodule

// File: tb/tb_assoc_cache_lru.sv
// Directed, table-driven bench for assoc_cache_lru (ENTRIES=8).
module tb_assoc_cache_lru;
    localparam logic [1:0] OP_FLUSH = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_INVAL = 2'b11;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    assoc_cache_if #(.TAG_WIDTH(16), .DATA_WIDTH(32), .ENTRIES(8)) bus ();

    assoc_cache_lru #(.TAG_WIDTH(16), .DATA_WIDTH(32), .ENTRIES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] tag;
        logic [31:0] data;
        logic        hit;
        logic        chk_data;
        logic [31:0] rdata;
        logic        ev;
        logic [15:0] etag;
        logic [31:0] edata;
        int          occ;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] op, input logic [15:0] tag,
                                input logic [31:0] data, input logic hit,
                                input logic cd, input logic [31:0] rd,
                                input logic ev, input logic [15:0] et,
                                input logic [31:0] ed, input int occ, input int lat);
        vec_t v;
        v.op = op; v.tag = tag; v.data = data; v.hit = hit; v.chk_data = cd;
        v.rdata = rd; v.ev = ev; v.etag = et; v.edata = ed; v.occ = occ; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int lat;
        @(negedge clk);
        chk({nm, ".req_ready"}, 64'(bus.req_ready), 64'd1);
        bus.req_valid  = 1'b1;
        bus.req_op     = v.op;
        bus.req_tag    = v.tag;
        bus.req_data   = v.data;
        bus.resp_ready = 1'b0;
        @(posedge clk);
        #1;
        // Scramble the request fields after the accepting edge.
        bus.req_valid = 1'b0;
        bus.req_op    = ~v.op;
        bus.req_tag   = ~v.tag;
        bus.req_data  = ~v.data;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.resp_valid && lat < 40);
        chk({nm, ".latency"}, 64'(lat), 64'(v.lat));
        chk({nm, ".hit"}, 64'(bus.resp_hit), 64'(v.hit));
        if (v.chk_data) begin
            chk({nm, ".data"}, 64'(bus.resp_data), 64'(v.rdata));
        end
        chk({nm, ".evict_valid"}, 64'(bus.evict_valid), 64'(v.ev));
        if (v.ev) begin
            chk({nm, ".evict_tag"}, 64'(bus.evict_tag), 64'(v.etag));
            chk({nm, ".evict_data"}, 64'(bus.evict_data), 64'(v.edata));
        end
        chk({nm, ".occupancy"}, 64'(bus.occupancy), 64'(v.occ));
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        int c;
        passed = 0;
        total  = 0;
        rst = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'b00;
        bus.req_tag    = 16'h0000;
        bus.req_data   = 32'h0000_0000;
        bus.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state.
        chk("rst.req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst.resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst.resp_data", 64'(bus.resp_data), 64'd0);
        chk("rst.evict_valid", 64'(bus.evict_valid), 64'd0);
        chk("rst.occupancy", 64'(bus.occupancy), 64'd0);

        // Vector table: T1, T2, hit/invalidate paths, T3 fill/evict, flush.
        vecs.push_back(mk(OP_READ,  16'h1234, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 16'h0, 32'h0, 0, 2));
        vecs.push_back(mk(OP_WRITE, 16'h0001, 32'hAAAA5555, 1'b0, 1'b1, 32'hAAAA5555, 1'b0, 16'h0, 32'h0, 1, 2));
        vecs.push_back(mk(OP_READ,  16'h0001, 32'h0, 1'b1, 1'b1, 32'hAAAA5555, 1'b0, 16'h0, 32'h0, 1, 2));
        vecs.push_back(mk(OP_WRITE, 16'h0001, 32'h12345678, 1'b1, 1'b1, 32'h12345678, 1'b0, 16'h0, 32'h0, 1, 2));
        vecs.push_back(mk(OP_INVAL, 16'h0001, 32'h0, 1'b1, 1'b1, 32'h12345678, 1'b0, 16'h0, 32'h0, 0, 2));
        vecs.push_back(mk(OP_INVAL, 16'h0001, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 16'h0, 32'h0, 0, 2));
        vecs.push_back(mk(OP_READ,  16'h0001, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 16'h0, 32'h0, 0, 2));
        for (int t = 1; t <= 8; t++) begin
            vecs.push_back(mk(OP_WRITE, 16'(t), 32'h100 + 32'(t), 1'b0, 1'b0, 32'h0,
                              1'b0, 16'h0, 32'h0, t, 2));
        end
        vecs.push_back(mk(OP_READ,  16'h0001, 32'h0, 1'b1, 1'b1, 32'h101, 1'b0, 16'h0, 32'h0, 8, 2));
        vecs.push_back(mk(OP_WRITE, 16'h0009, 32'h109, 1'b0, 1'b0, 32'h0, 1'b1, 16'h0002, 32'h102, 8, 2));
        vecs.push_back(mk(OP_READ,  16'h0002, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 16'h0, 32'h0, 8, 2));
        vecs.push_back(mk(OP_READ,  16'h0001, 32'h0, 1'b1, 1'b1, 32'h101, 1'b0, 16'h0, 32'h0, 8, 2));
        vecs.push_back(mk(OP_READ,  16'h0009, 32'h0, 1'b1, 1'b1, 32'h109, 1'b0, 16'h0, 32'h0, 8, 2));
        vecs.push_back(mk(OP_WRITE, 16'h000A, 32'h10A, 1'b0, 1'b0, 32'h0, 1'b1, 16'h0003, 32'h103, 8, 2));
        vecs.push_back(mk(OP_FLUSH, 16'h0000, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 16'h0, 32'h0, 0, 9));
        vecs.push_back(mk(OP_READ,  16'h0001, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 16'h0, 32'h0, 0, 2));
        vecs.push_back(mk(OP_READ,  16'h000A, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 16'h0, 32'h0, 0, 2));

        foreach (vecs[i]) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // T4: response held while resp_ready stays low.
        run_vec(mk(OP_WRITE, 16'h0055, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 1'b0, 16'h0, 32'h0, 1, 2), "t4.wr");
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_READ;
        bus.req_tag   = 16'h0055;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        c = 0;
        while (!bus.resp_valid && c < 40) begin
            @(posedge clk);
            #1;
            c++;
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("t4.hold_valid", 64'(bus.resp_valid), 64'd1);
            chk("t4.hold_hit", 64'(bus.resp_hit), 64'd1);
            chk("t4.hold_data", 64'(bus.resp_data), 64'hDEADBEEF);
            chk("t4.hold_req_ready", 64'(bus.req_ready), 64'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        chk("t4.released_valid", 64'(bus.resp_valid), 64'd0);
        chk("t4.released_req_ready", 64'(bus.req_ready), 64'd1);

        // T5: three more lines, flush, then all miss.
        run_vec(mk(OP_WRITE, 16'h0010, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0, 16'h0, 32'h0, 2, 2), "t5.w0");
        run_vec(mk(OP_WRITE, 16'h0020, 32'h20, 1'b0, 1'b0, 32'h0, 1'b0, 16'h0, 32'h0, 3, 2), "t5.w1");
        run_vec(mk(OP_WRITE, 16'h0030, 32'h30, 1'b0, 1'b0, 32'h0, 1'b0, 16'h0, 32'h0, 4, 2), "t5.w2");
        run_vec(mk(OP_FLUSH, 16'h0000, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 16'h0, 32'h0, 0, 9), "t5.flush");
        run_vec(mk(OP_READ, 16'h0010, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 16'h0, 32'h0, 0, 2), "t5.r0");
        run_vec(mk(OP_READ, 16'h0020, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 16'h0, 32'h0, 0, 2), "t5.r1");
        run_vec(mk(OP_READ, 16'h0030, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 16'h0, 32'h0, 0, 2), "t5.r2");

        // T6a: reset in the middle of a flush.
        run_vec(mk(OP_WRITE, 16'h0077, 32'h77, 1'b0, 1'b0, 32'h0, 1'b0, 16'h0, 32'h0, 1, 2), "t6.w0");
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_FLUSH;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t6a.resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("t6a.req_ready", 64'(bus.req_ready), 64'd1);
        chk("t6a.occupancy", 64'(bus.occupancy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(mk(OP_READ, 16'h0077, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 16'h0, 32'h0, 0, 2), "t6a.r");

        // T6b: reset while a hit response is pending.
        run_vec(mk(OP_WRITE, 16'h0088, 32'h88, 1'b0, 1'b0, 32'h0, 1'b0, 16'h0, 32'h0, 1, 2), "t6b.w");
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_READ;
        bus.req_tag   = 16'h0088;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        c = 0;
        while (!bus.resp_valid && c < 40) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("t6b.pre_hit", 64'(bus.resp_hit), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6b.resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("t6b.resp_hit", 64'(bus.resp_hit), 64'd0);
        chk("t6b.resp_data", 64'(bus.resp_data), 64'd0);
        chk("t6b.occupancy", 64'(bus.occupancy), 64'd0);
        chk("t6b.req_ready", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        run_vec(mk(OP_READ, 16'h0088, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 16'h0, 32'h0, 0, 2), "t6b.r");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
